ofdm_frame_ctrl: RTL and testbench
==================================

Name: ofdm_frame_ctrl

Overview:
- Parametrised master controller for the OFDM baseband modulator chain: S2P -> QAM -> S2P_REG -> IFFT -> CPI/serializer.
- Counts subcarriers internally and sequences a multi-symbol frame of a programmable length.
- Waits on real IFFT completion, tolerates multi-cycle QAM latency, and supports abort.
- Sits at the top of the modulator datapath and drives all stage start strobes.

Parameters:
- N_SC, 64, subcarriers per OFDM symbol (QAM outputs registered per symbol); N_SC >= 2.
- QAM_LAT, 1, cycles spent in QAM state (>= 1).
- SYM_W, 8, width of the symbol count/index.
- WD_CYCLES, 4096, watchdog limit in cycles; used only with the optional feature.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- go  in  1  frame request; sampled in IDLE only.
- num_sym  in  SYM_W  symbols in frame; latched on an accepted go.
- abort  in  1  synchronous abort of the current frame.
- s2p_done  in  1  S2P finished one QAM word.
- ifft_done  in  1  IFFT finished.
- cpi_done  in  1  CPI/serializer finished the symbol.
- s2p_start  out  1  level; held until s2p_done.
- s2p_reg_start  out  1  one-cycle pulse; register current QAM output.
- ifft_start  out  1  one-cycle pulse.
- cpi_start  out  1  one-cycle pulse.
- cpi_data_valid  out  1  one-cycle pulse, coincident with cpi_start.
- busy  out  1  high in every non-IDLE state.
- sc_idx  out  $clog2(N_SC)  current subcarrier index.
- sym_idx  out  SYM_W  current symbol index.
- frame_done  out  1  one-cycle pulse at frame end.
- err  out  1  sticky watchdog error.

Behaviour:
- Reset: all outputs 0; FSM in IDLE.
- All outputs are registered. Each strobe rises on the same edge the FSM enters the state that owns it.
- States: IDLE, S2P, QAM, REG, IFFT, CPI, DONE.
- IDLE:
  - go=1 and num_sym!=0 -> S2P. Latch num_sym; sc_idx=0; sym_idx=0; s2p_start<=1; err<=0.
  - go with num_sym==0 is ignored.
- S2P: on s2p_done -> QAM, s2p_start<=0, load QAM counter = QAM_LAT-1.
- QAM:
  - Counter>0: decrement.
  - Counter==0: -> REG with s2p_reg_start<=1.
  - QAM_LAT=1 gives exactly one QAM cycle.
- REG:
  - s2p_reg_start<=0.
  - If sc_idx==N_SC-1: -> IFFT, ifft_start<=1, sc_idx<=0.
  - Else: sc_idx++, -> S2P, s2p_start<=1.
- IFFT:
  - ifft_start drops after one cycle.
  - On ifft_done: -> CPI with cpi_start<=1 and cpi_data_valid<=1 for one cycle.
- CPI: on cpi_done:
  - If sym_idx==num_sym_latched-1: -> DONE.
  - Else: sym_idx++, -> S2P, s2p_start<=1.
- DONE: frame_done<=1 for one cycle; busy<=0; -> IDLE.
- Done inputs arriving in any state other than their own waiting state are ignored.
- go while busy is ignored.
- abort in any non-IDLE state:
  - Next edge -> IDLE; all strobes 0; busy 0; sc_idx and sym_idx hold their last values.
  - frame_done is not asserted.
  - abort has priority over a simultaneous done input.
- abort in IDLE has no effect. If go and abort are both high in IDLE, abort wins: the frame does not start.
- Cycles per symbol with zero-latency handshakes: N_SC*(2+QAM_LAT) + IFFT wait + CPI wait.

Optional Feature:
- Macro: OFDM_CTRL_WATCHDOG_EN.
- With the macro defined:
  - A cycle counter clears on every state change.
  - If the FSM stays in S2P, IFFT or CPI for WD_CYCLES consecutive cycles: err<=1 (sticky), -> IDLE, strobes cleared, frame_done not asserted.
  - err clears on the next accepted go.
- Without the macro: err is tied to 0 and waiting states wait indefinitely.

Decomposition:
- Shared package ofdm_ctrl_pkg holds:
  - the state encoding constants (IDLE=0 .. DONE=6, 3-bit);
  - the SC_W = $clog2(N_SC) helper;
  - default N_SC, QAM_LAT and SYM_W values shared with the datapath blocks.
- Sub-module ofdm_ctrl_watchdog (counter, clear, timeout flag) is instantiated only under the macro.

Test Plan:
- N_SC=4, QAM_LAT=2, num_sym=1, s2p_done 3 cycles after each s2p_start, ifft_done 5 cycles after ifft_start, cpi_done 10 cycles later -> exactly 4 s2p_reg_start pulses, sc_idx 0..3, 1 ifft_start, 1 cpi_start coincident with cpi_data_valid, 1 frame_done, busy low the cycle after.
- num_sym=3 -> 12 s2p_reg_start, 3 ifft_start, 3 cpi_start, sym_idx 0,1,2, single frame_done after the third cpi_done.
- go with num_sym=0 -> stays IDLE, busy=0, no strobes; go pulsed while busy mid-frame -> ignored, frame counts unchanged.
- abort asserted in IFFT, coincident with ifft_done -> IDLE next cycle, no cpi_start, no frame_done; a new go then runs a full frame from sc_idx=0, sym_idx=0.
- Spurious cpi_done during S2P, and s2p_done during IFFT -> no state change.
- With OFDM_CTRL_WATCHDOG_EN and WD_CYCLES=16, ifft_done withheld -> err=1 after 16 cycles in IFFT, busy=0, no frame_done; next go clears err.

Source files
------------

// File: rtl/ofdm_ctrl_pkg.sv
// ofdm_ctrl_pkg
// Shared definitions for the OFDM modulator controller and its datapath
// neighbours: FSM state encoding, subcarrier-index width helper and the
// default chain dimensions.
package ofdm_ctrl_pkg;

    localparam int unsigned DEF_N_SC    = 64;
    localparam int unsigned DEF_QAM_LAT = 1;
    localparam int unsigned DEF_SYM_W   = 8;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_S2P  = 3'd1,
        ST_QAM  = 3'd2,
        ST_REG  = 3'd3,
        ST_IFFT = 3'd4,
        ST_CPI  = 3'd5,
        ST_DONE = 3'd6
    } state_t;

    // Width of a subcarrier index for n subcarriers (n >= 2).
    function automatic int unsigned sc_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ofdm_ctrl_watchdog.sv
// ofdm_ctrl_watchdog
// Counts consecutive cycles spent in a waiting state and flags a timeout on
// the WD_CYCLES-th such cycle.
// Ports:
//   clk, rst  clock, asynchronous active-low reset
//   restart   controller changes state this cycle; counter restarts at 0
//   en        controller is in a state that is being watched
//   timeout   current cycle is the WD_CYCLES-th consecutive watched cycle
module ofdm_ctrl_watchdog #(
    parameter int unsigned WD_CYCLES = 4096
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    input  logic en,
    output logic timeout
);

    localparam int unsigned CW = $clog2(WD_CYCLES + 1);

    logic [CW-1:0] cnt;

    assign timeout = en && (cnt == CW'(WD_CYCLES - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (restart) begin
            cnt <= '0;
        end else if (en && !timeout) begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/ofdm_frame_ctrl.sv
// ofdm_frame_ctrl
// Master sequencer for the OFDM modulator chain
// S2P -> QAM -> S2P_REG -> IFFT -> CPI. Runs num_sym symbols of N_SC
// subcarriers each, handshaking with every stage, with synchronous abort.
// Optional build macro OFDM_CTRL_WATCHDOG_EN: times out S2P/IFFT/CPI waits
// after WD_CYCLES cycles and raises sticky err; without it err is 0.
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   go, num_sym     frame request and its symbol count (accepted in IDLE)
//   abort           return to IDLE at the next edge
//   s2p_done, ifft_done, cpi_done   stage completion inputs
//   s2p_start       level, held until s2p_done
//   s2p_reg_start, ifft_start, cpi_start, cpi_data_valid   one-cycle strobes
//   busy            high in every non-IDLE state
//   sc_idx, sym_idx current subcarrier / symbol index
//   frame_done      one-cycle pulse at frame end
//   err             sticky watchdog error
module ofdm_frame_ctrl
    import ofdm_ctrl_pkg::*;
#(
    parameter int unsigned N_SC      = DEF_N_SC,
    parameter int unsigned QAM_LAT   = DEF_QAM_LAT,
    parameter int unsigned SYM_W     = DEF_SYM_W,
    parameter int unsigned WD_CYCLES = 4096
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     go,
    input  logic [SYM_W-1:0]         num_sym,
    input  logic                     abort,
    input  logic                     s2p_done,
    input  logic                     ifft_done,
    input  logic                     cpi_done,
    output logic                     s2p_start,
    output logic                     s2p_reg_start,
    output logic                     ifft_start,
    output logic                     cpi_start,
    output logic                     cpi_data_valid,
    output logic                     busy,
    output logic [sc_w(N_SC)-1:0]    sc_idx,
    output logic [SYM_W-1:0]         sym_idx,
    output logic                     frame_done,
    output logic                     err
);

    localparam int unsigned SC_W = sc_w(N_SC);
    localparam int unsigned QW   = (QAM_LAT > 1) ? $clog2(QAM_LAT) : 1;

    state_t            state_q, state_d;
    logic [QW-1:0]     qcnt_q, qcnt_d;
    logic [SYM_W-1:0]  nsym_q, nsym_d;
    logic [SYM_W-1:0]  sym_d;
    logic [SC_W-1:0]   sc_d;
    logic              s2p_start_d, reg_d, ifft_d, cpi_d, fd_d;

`ifdef OFDM_CTRL_WATCHDOG_EN
    logic wd_timeout;
    logic err_d;

    ofdm_ctrl_watchdog #(
        .WD_CYCLES(WD_CYCLES)
    ) u_wd (
        .clk     (clk),
        .rst     (rst),
        .restart (state_d != state_q),
        .en      (state_q == ST_S2P || state_q == ST_IFFT || state_q == ST_CPI),
        .timeout (wd_timeout)
    );
`else
    assign err = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        qcnt_d      = qcnt_q;
        nsym_d      = nsym_q;
        sc_d        = sc_idx;
        sym_d       = sym_idx;
        s2p_start_d = s2p_start;
        reg_d       = 1'b0;
        ifft_d      = 1'b0;
        cpi_d       = 1'b0;
        fd_d        = 1'b0;
`ifdef OFDM_CTRL_WATCHDOG_EN
        err_d       = err;
`endif
        case (state_q)
            ST_IDLE: begin
                if (go && !abort && num_sym != '0) begin
                    state_d     = ST_S2P;
                    nsym_d      = num_sym;
                    sc_d        = '0;
                    sym_d       = '0;
                    s2p_start_d = 1'b1;
`ifdef OFDM_CTRL_WATCHDOG_EN
                    err_d       = 1'b0;
`endif
                end
            end
            ST_S2P: begin
                if (s2p_done) begin
                    state_d     = ST_QAM;
                    s2p_start_d = 1'b0;
                    qcnt_d      = QW'(QAM_LAT - 1);
                end
            end
            ST_QAM: begin
                if (qcnt_q != '0) begin
                    qcnt_d = qcnt_q - QW'(1);
                end else begin
                    state_d = ST_REG;
                    reg_d   = 1'b1;
                end
            end
            ST_REG: begin
                if (sc_idx == SC_W'(N_SC - 1)) begin
                    state_d = ST_IFFT;
                    ifft_d  = 1'b1;
                    sc_d    = '0;
                end else begin
                    state_d     = ST_S2P;
                    sc_d        = sc_idx + SC_W'(1);
                    s2p_start_d = 1'b1;
                end
            end
            ST_IFFT: begin
                if (ifft_done) begin
                    state_d = ST_CPI;
                    cpi_d   = 1'b1;
                end
            end
            ST_CPI: begin
                if (cpi_done) begin
                    if (sym_idx == nsym_q - SYM_W'(1)) begin
                        state_d = ST_DONE;
                        fd_d    = 1'b1;
                    end else begin
                        state_d     = ST_S2P;
                        sym_d       = sym_idx + SYM_W'(1);
                        s2p_start_d = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

`ifdef OFDM_CTRL_WATCHDOG_EN
        if (wd_timeout) begin
            state_d     = ST_IDLE;
            err_d       = 1'b1;
            s2p_start_d = 1'b0;
            reg_d       = 1'b0;
            ifft_d      = 1'b0;
            cpi_d       = 1'b0;
            fd_d        = 1'b0;
            sc_d        = sc_idx;
            sym_d       = sym_idx;
        end
`endif

        // Abort overrides every transition above, including one triggered by
        // a done input in the same cycle; indices keep their current values.
        if (abort && state_q != ST_IDLE) begin
            state_d     = ST_IDLE;
            s2p_start_d = 1'b0;
            reg_d       = 1'b0;
            ifft_d      = 1'b0;
            cpi_d       = 1'b0;
            fd_d        = 1'b0;
            sc_d        = sc_idx;
            sym_d       = sym_idx;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= ST_IDLE;
            qcnt_q         <= '0;
            nsym_q         <= '0;
            sc_idx         <= '0;
            sym_idx        <= '0;
            s2p_start      <= 1'b0;
            s2p_reg_start  <= 1'b0;
            ifft_start     <= 1'b0;
            cpi_start      <= 1'b0;
            cpi_data_valid <= 1'b0;
            frame_done     <= 1'b0;
            busy           <= 1'b0;
`ifdef OFDM_CTRL_WATCHDOG_EN
            err            <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            qcnt_q         <= qcnt_d;
            nsym_q         <= nsym_d;
            sc_idx         <= sc_d;
            sym_idx        <= sym_d;
            s2p_start      <= s2p_start_d;
            s2p_reg_start  <= reg_d;
            ifft_start     <= ifft_d;
            cpi_start      <= cpi_d;
            cpi_data_valid <= cpi_d;
            frame_done     <= fd_d;
            busy           <= (state_d != ST_IDLE);
`ifdef OFDM_CTRL_WATCHDOG_EN
            err            <= err_d;
`endif
        end
    end

endmodule

// File: tb/tb_ofdm_frame_ctrl.sv
// tb_ofdm_frame_ctrl
// Frame-level reference model: each frame is expanded into a per-cycle table
// of expected outputs from handshake delays drawn in advance; the bench plays
// the matching input table and one compare process checks every cycle.
module tb_ofdm_frame_ctrl;

    localparam int N_SC    = 4;
    localparam int QAM_LAT = 2;
    localparam int SYM_W   = 8;
    localparam int WD      = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             go = 1'b0, abort = 1'b0;
    logic             s2p_done = 1'b0, ifft_done = 1'b0, cpi_done = 1'b0;
    logic [SYM_W-1:0] num_sym = '0;
    logic             s2p_start, s2p_reg_start, ifft_start, cpi_start;
    logic             cpi_data_valid, busy, frame_done, err;
    logic [1:0]       sc_idx;
    logic [SYM_W-1:0] sym_idx;

    always #5 clk = ~clk;

    ofdm_frame_ctrl #(
        .N_SC      (N_SC),
        .QAM_LAT   (QAM_LAT),
        .SYM_W     (SYM_W),
        .WD_CYCLES (WD)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .go             (go),
        .num_sym        (num_sym),
        .abort          (abort),
        .s2p_done       (s2p_done),
        .ifft_done      (ifft_done),
        .cpi_done       (cpi_done),
        .s2p_start      (s2p_start),
        .s2p_reg_start  (s2p_reg_start),
        .ifft_start     (ifft_start),
        .cpi_start      (cpi_start),
        .cpi_data_valid (cpi_data_valid),
        .busy           (busy),
        .sc_idx         (sc_idx),
        .sym_idx        (sym_idx),
        .frame_done     (frame_done),
        .err            (err)
    );

    typedef struct {
        bit s2p, rg, ifft, cpi, busy, fd, err;
        int sc, sym;
    } exp_t;

    typedef struct {
        bit go, sd, id, cd, ab;
        int ns;
    } in_t;

    in_t  tin[$];
    exp_t tex[$];
    exp_t chk_q[$];

    int total = 0;
    int bad   = 0;
    int last_sc = 0, last_sym = 0;
    bit cur_err = 1'b0;
    int ifft_end_idx = 0;

    int cnt_rg = 0, cnt_ifft = 0, cnt_cpi = 0, cnt_fd = 0, cnt_busy = 0;
    int b_rg, b_ifft, b_cpi, b_fd, b_busy;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at t=%0t", name, act, req, $time);
        end
    endtask

    // Random stimulus on inputs that must be ignored in the current state.
    function automatic in_t noise(input bit sd_ok, input bit id_ok, input bit cd_ok, input bit go_ok);
        in_t i;
        i.go = go_ok && ($urandom_range(0, 5) == 0);
        i.ns = $urandom_range(0, 4);
        i.sd = sd_ok && ($urandom_range(0, 3) == 0);
        i.id = id_ok && ($urandom_range(0, 3) == 0);
        i.cd = cd_ok && ($urandom_range(0, 3) == 0);
        i.ab = 1'b0;
        return i;
    endfunction

    function automatic int dly(input int f);
        return (f < 0) ? int'($urandom_range(0, 3)) : f;
    endfunction

    function automatic void add(input bit s2p, input bit rg, input bit ifft, input bit cpi,
                                input bit fd, input bit bsy, input int sc, input int sym,
                                input in_t i);
        exp_t e;
        e.s2p = s2p; e.rg = rg; e.ifft = ifft; e.cpi = cpi; e.fd = fd;
        e.busy = bsy; e.err = cur_err; e.sc = sc; e.sym = sym;
        tex.push_back(e);
        tin.push_back(i);
    endfunction

    function automatic void add_idle(input int sc, input int sym, input in_t i);
        add(0, 0, 0, 0, 0, 0, sc, sym, i);
        last_sc  = sc;
        last_sym = sym;
    endfunction

    // amode: 0 none, 1 abort at a random busy cycle, 2 abort on the last
    // IFFT cycle of symbol 0 (coincident with ifft_done).
    function automatic void build_frame(input int n, input int fs, input int fi, input int fc,
                                        input int amode, input bit gab, input bit wd);
        int start, d, a;
        in_t i;
        start = tex.size();
        i = noise(1, 1, 1, 0);
        i.go = 1'b1; i.ns = n; i.ab = gab;
        add(0, 0, 0, 0, 0, 0, last_sc, last_sym, i);
        if (n == 0 || gab) begin
            add_idle(last_sc, last_sym, noise(1, 1, 1, 0));
            return;
        end
        cur_err = 1'b0;
        for (int s = 0; s < n; s++) begin
            for (int c = 0; c < N_SC; c++) begin
                d = dly(fs);
                for (int j = 0; j <= d; j++) begin
                    i = noise(0, 1, 1, 1);
                    i.sd = (j == d);
                    add(1, 0, 0, 0, 0, 1, c, s, i);
                end
                for (int j = 0; j < QAM_LAT; j++) add(0, 0, 0, 0, 0, 1, c, s, noise(1, 1, 1, 1));
                add(0, 1, 0, 0, 0, 1, c, s, noise(1, 1, 1, 1));
            end
            if (wd) begin
                for (int j = 0; j < WD; j++) add(0, 0, j == 0, 0, 0, 1, 0, s, noise(1, 0, 1, 1));
                cur_err = 1'b1;
                add_idle(0, s, noise(1, 1, 1, 0));
                return;
            end
            d = dly(fi);
            for (int j = 0; j <= d; j++) begin
                i = noise(1, 0, 1, 1);
                i.id = (j == d);
                if (j == d && s == 0) ifft_end_idx = tex.size();
                add(0, 0, j == 0, 0, 0, 1, 0, s, i);
            end
            d = dly(fc);
            for (int j = 0; j <= d; j++) begin
                i = noise(1, 1, 0, 1);
                i.cd = (j == d);
                add(0, 0, 0, j == 0, 0, 1, 0, s, i);
            end
        end
        add(0, 0, 0, 0, 1, 1, 0, n - 1, noise(1, 1, 1, 1));
        add_idle(0, n - 1, noise(1, 1, 1, 0));
        if (amode != 0) begin
            a = (amode == 1) ? start + int'($urandom_range(1, tex.size() - start - 2)) : ifft_end_idx;
            i = tin[a];
            i.ab = 1'b1;
            tin[a] = i;
            while (tex.size() > a + 1) begin
                void'(tex.pop_back());
                void'(tin.pop_back());
            end
            add_idle(tex[a].sc, tex[a].sym, noise(1, 1, 1, 0));
        end
    endfunction

    task automatic play();
        b_rg = cnt_rg; b_ifft = cnt_ifft; b_cpi = cnt_cpi; b_fd = cnt_fd; b_busy = cnt_busy;
        for (int k = 0; k < tin.size(); k++) begin
            @(posedge clk);
            #1;
            go        = tin[k].go;
            num_sym   = SYM_W'(tin[k].ns);
            s2p_done  = tin[k].sd;
            ifft_done = tin[k].id;
            cpi_done  = tin[k].cd;
            abort     = tin[k].ab;
            chk_q.push_back(tex[k]);
        end
        @(posedge clk);
        #1;
        go = 0; s2p_done = 0; ifft_done = 0; cpi_done = 0; abort = 0; num_sym = '0;
        @(negedge clk);
        tin.delete();
        tex.delete();
    endtask

    always @(negedge clk) begin
        if (rst) begin
            cnt_rg   += int'(s2p_reg_start);
            cnt_ifft += int'(ifft_start);
            cnt_cpi  += int'(cpi_start);
            cnt_fd   += int'(frame_done);
            cnt_busy += int'(busy);
        end
    end

    // Per-cycle compare of the full output vector against the model table.
    always @(negedge clk) begin
        exp_t e;
        logic [1:0]  esc;
        logic [7:0]  esym;
        if (chk_q.size() > 0) begin
            e = chk_q.pop_front();
            esc  = e.sc[1:0];
            esym = e.sym[7:0];
            check("cycle_outputs",
                  {8'h0, s2p_start, s2p_reg_start, ifft_start, cpi_start, cpi_data_valid,
                   busy, frame_done, err, 6'h0, sc_idx, sym_idx},
                  {8'h0, e.s2p, e.rg, e.ifft, e.cpi, e.cpi, e.busy, e.fd, e.err,
                   6'h0, esc, esym});
        end
    end

    initial begin
        rst = 1'b1;
        #3 rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_strobes", {s2p_start, s2p_reg_start, ifft_start, cpi_start, cpi_data_valid}, 0);
        check("rst_busy_done_err", {busy, frame_done, err}, 0);
        check("rst_sc_idx", sc_idx, 0);
        check("rst_sym_idx", sym_idx, 0);
        rst = 1'b1;

        // One symbol, fixed delays 3/5/10.
        build_frame(1, 3, 5, 10, 0, 0, 0);
        check("model_len_1sym", tex.size(), 48);
        play();
        check("n1_reg_pulses", cnt_rg - b_rg, 4);
        check("n1_ifft_pulses", cnt_ifft - b_ifft, 1);
        check("n1_cpi_pulses", cnt_cpi - b_cpi, 1);
        check("n1_frame_done", cnt_fd - b_fd, 1);
        check("n1_busy_cycles", cnt_busy - b_busy, 46);

        // Three symbols.
        build_frame(3, 3, 5, 10, 0, 0, 0);
        check("model_len_3sym", tex.size(), 138);
        play();
        check("n3_reg_pulses", cnt_rg - b_rg, 12);
        check("n3_ifft_pulses", cnt_ifft - b_ifft, 3);
        check("n3_cpi_pulses", cnt_cpi - b_cpi, 3);
        check("n3_frame_done", cnt_fd - b_fd, 1);

        // Ignored requests: num_sym==0, and go together with abort.
        build_frame(0, -1, -1, -1, 0, 0, 0);
        play();
        build_frame(2, -1, -1, -1, 0, 1, 0);
        play();
        check("ignored_go_busy", cnt_busy - b_busy, 0);

        // Abort coincident with ifft_done, then a full fresh frame.
        build_frame(2, 0, 2, 1, 2, 0, 0);
        play();
        check("abort_ifft_cpi", cnt_cpi - b_cpi, 0);
        check("abort_ifft_fd", cnt_fd - b_fd, 0);
        build_frame(2, -1, -1, -1, 0, 0, 0);
        play();
        check("after_abort_fd", cnt_fd - b_fd, 1);

        for (int r = 0; r < 25; r++) begin
            build_frame($urandom_range(0, 4), -1, -1, -1,
                        ($urandom_range(0, 3) == 0) ? 1 : 0,
                        $urandom_range(0, 19) == 0, 0);
            play();
        end

`ifdef OFDM_CTRL_WATCHDOG_EN
        build_frame(1, 0, 0, 0, 0, 0, 1);
        play();
        check("wd_err_set", err, 1);
        check("wd_busy_low", busy, 0);
        check("wd_no_frame_done", cnt_fd - b_fd, 0);
        build_frame(1, -1, -1, -1, 0, 0, 0);
        play();
        check("wd_err_cleared", err, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
